// File: rtl/upg_uart_loader.sv
// UART (8N1, LSB first) program-image loader driving the data-memory programming port.
// Optional trailing XOR checksum byte is enabled by defining UPG_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module upg_uart_loader #(
    parameter int CLK_FREQ = 10000000,
    parameter int BAUD     = 128000,
    parameter int ADR_W    = 14
) (
    input  logic             upg_clk_i,
    input  logic             upg_rstn_i,
    input  logic             rx_i,
    output logic             upg_wen_o,
    output logic [ADR_W-1:0] upg_adr_o,
    output logic [31:0]      upg_dat_o,
    output logic             upg_done_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [16:0]      N_MAX     = 17'd1 << ADR_W;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
`ifdef UPG_LOADER_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } ld_state_t;

`ifdef UPG_LOADER_CHECKSUM_EN
    localparam ld_state_t S_AFTER = S_CHK;
`else
    localparam ld_state_t S_AFTER = S_DONE;
`endif

    logic             rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t        rx_state_r, rx_state_s;
    logic [CNT_W-1:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]       rx_bit_r, rx_bit_s;
    logic [7:0]       rx_shift_r, rx_shift_s;
    logic             byte_valid_s, frame_err_s, start_det_s;
    logic             byte_valid_r, frame_err_r;

    ld_state_t        ld_state_r, ld_state_s;
    logic [15:0]      len_r, len_s;
    logic [1:0]       byte_cnt_r;
    logic [23:0]      word_r;
    logic [ADR_W-1:0] wr_adr_r;
    logic             last_word_s, done_set_s;
    logic             wen_r, done_r, busy_r, err_r;
    logic [ADR_W-1:0] adr_r;
    logic [31:0]      dat_r;
`ifdef UPG_LOADER_CHECKSUM_EN
    logic [7:0]       chk_r;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX byte engine next-state: mid-bit sampling driven by a single cycle counter
    always_comb begin
        rx_state_s   = rx_state_r;
        rx_cnt_s     = rx_cnt_r + CNT_W'(1);
        rx_bit_s     = rx_bit_r;
        rx_shift_s   = rx_shift_r;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        start_det_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_s = '0;
                if (rx_prev_r && !rx_sync_r) begin
                    start_det_s = 1'b1;
                    rx_state_s  = RX_START;
                end else begin
                    rx_state_s  = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_s   = '0;
                    rx_bit_s   = 3'd0;
                    rx_state_s = rx_sync_r ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    rx_bit_s   = rx_bit_r + 3'd1;
                    rx_state_s = (rx_bit_r == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    rx_state_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s     = '0;
                    rx_state_s   = RX_IDLE;
                    byte_valid_s = rx_sync_r;
                    frame_err_s  = !rx_sync_r;
                end else begin
                    rx_state_s   = RX_STOP;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
            end
        endcase
    end

    // RX engine state and registered byte/framing pulses
    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            rx_state_r   <= RX_IDLE;
            rx_cnt_r     <= '0;
            rx_bit_r     <= 3'd0;
            rx_shift_r   <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rx_state_r   <= rx_state_s;
            rx_cnt_r     <= rx_cnt_s;
            rx_bit_r     <= rx_bit_s;
            rx_shift_r   <= rx_shift_s;
            byte_valid_r <= byte_valid_s;
            frame_err_r  <= frame_err_s;
        end
    end

    // Loader next-state: length header, data words, optional checksum, terminal states
    always_comb begin
        ld_state_s  = ld_state_r;
        len_s       = {rx_shift_r, len_r[7:0]};
        last_word_s = (17'(wr_adr_r) == (17'(len_r) - 17'd1));
        done_set_s  = 1'b0;
        case (ld_state_r)
            S_LEN0: begin
                if (frame_err_r) begin
                    ld_state_s = S_ERR;
                end else if (byte_valid_r) begin
                    ld_state_s = S_LEN1;
                end else begin
                    ld_state_s = S_LEN0;
                end
            end
            S_LEN1: begin
                if (frame_err_r) begin
                    ld_state_s = S_ERR;
                end else if (byte_valid_r) begin
                    if (len_s == 16'd0) begin
                        ld_state_s = S_AFTER;
                    end else if ({1'b0, len_s} > N_MAX) begin
                        ld_state_s = S_ERR;
                    end else begin
                        ld_state_s = S_DATA;
                    end
                end else begin
                    ld_state_s = S_LEN1;
                end
            end
            S_DATA: begin
                if (frame_err_r) begin
                    ld_state_s = S_ERR;
                end else if (byte_valid_r && (byte_cnt_r == 2'd3) && last_word_s) begin
                    ld_state_s = S_AFTER;
                end else begin
                    ld_state_s = S_DATA;
                end
            end
`ifdef UPG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (frame_err_r) begin
                    ld_state_s = S_ERR;
                end else if (byte_valid_r) begin
                    if (rx_shift_r == chk_r) begin
                        ld_state_s = S_DONE;
                        done_set_s = 1'b1;
                    end else begin
                        ld_state_s = S_ERR;
                    end
                end else begin
                    ld_state_s = S_CHK;
                end
            end
`endif
            S_DONE: begin
                ld_state_s = S_DONE;
                done_set_s = 1'b1;
            end
            S_ERR: begin
                ld_state_s = S_ERR;
            end
            default: begin
                ld_state_s = S_ERR;
            end
        endcase
    end

    // Loader state, word assembly and registered memory-port outputs
    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            ld_state_r <= S_LEN0;
            len_r      <= 16'h0000;
            byte_cnt_r <= 2'd0;
            word_r     <= 24'h000000;
            wr_adr_r   <= '0;
            wen_r      <= 1'b0;
            adr_r      <= '0;
            dat_r      <= 32'h00000000;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
`ifdef UPG_LOADER_CHECKSUM_EN
            chk_r      <= 8'h00;
`endif
        end else begin
            ld_state_r <= ld_state_s;
            wen_r      <= 1'b0;
            done_r     <= done_set_s;
            err_r      <= (ld_state_r == S_ERR);
            if ((ld_state_r == S_DONE) || (ld_state_r == S_ERR) || done_set_s) begin
                busy_r <= 1'b0;
            end else if (start_det_s) begin
                busy_r <= 1'b1;
            end else begin
                busy_r <= busy_r;
            end
            if (byte_valid_r && (ld_state_r == S_LEN0)) begin
                len_r[7:0] <= rx_shift_r;
            end else if (byte_valid_r && (ld_state_r == S_LEN1)) begin
                len_r[15:8] <= rx_shift_r;
                byte_cnt_r  <= 2'd0;
                wr_adr_r    <= '0;
`ifdef UPG_LOADER_CHECKSUM_EN
                chk_r       <= 8'h00;
`endif
            end else if (byte_valid_r && (ld_state_r == S_DATA)) begin
`ifdef UPG_LOADER_CHECKSUM_EN
                chk_r      <= chk_r ^ rx_shift_r;
`endif
                byte_cnt_r <= byte_cnt_r + 2'd1;
                case (byte_cnt_r)
                    2'd0: word_r[7:0]   <= rx_shift_r;
                    2'd1: word_r[15:8]  <= rx_shift_r;
                    2'd2: word_r[23:16] <= rx_shift_r;
                    2'd3: begin
                        wen_r    <= 1'b1;
                        adr_r    <= wr_adr_r;
                        dat_r    <= {rx_shift_r, word_r};
                        wr_adr_r <= wr_adr_r + ADR_W'(1);
                    end
                    default: word_r <= word_r;
                endcase
            end else begin
                len_r <= len_r;
            end
        end
    end

    assign upg_wen_o  = wen_r;
    assign upg_adr_o  = adr_r;
    assign upg_dat_o  = dat_r;
    assign upg_done_o = done_r;
    assign busy_o     = busy_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_upg_uart_loader.sv
// Scoreboard bench for upg_uart_loader: frame-level model pushes expected writes, monitor pops on strobes.
`timescale 1ns/1ps
module tb_upg_uart_loader;

    localparam int CLK_FREQ = 10000000;
    localparam int BAUD     = 500000;
    localparam int ADR_W    = 14;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic             rx   = 1'b1;
    logic             upg_wen_o;
    logic [ADR_W-1:0] upg_adr_o;
    logic [31:0]      upg_dat_o;
    logic             upg_done_o;
    logic             busy_o;
    logic             err_o;

    int     checks  = 0;
    int     errors  = 0;
    int     strobes = 0;
    longint cyc = 0, strobe_cycle = 0, done_cycle = 0;
    logic   done_prev = 1'b0;
    logic [ADR_W-1:0] exp_adr_q[$];
    logic [31:0]      exp_dat_q[$];
    logic [31:0]      words_q[$];

    always #50 clk = ~clk;

    upg_uart_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADR_W(ADR_W)) dut (
        .upg_clk_i (clk),
        .upg_rstn_i(rstn),
        .rx_i      (rx),
        .upg_wen_o (upg_wen_o),
        .upg_adr_o (upg_adr_o),
        .upg_dat_o (upg_dat_o),
        .upg_done_o(upg_done_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the expected-write queue
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (upg_wen_o === 1'b1) begin
                strobes++;
                strobe_cycle = cyc;
                if (exp_adr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: actual adr=0x%0h dat=0x%0h required=no write",
                             upg_adr_o, upg_dat_o);
                end else begin
                    check("strobe_adr", 32'(upg_adr_o), 32'(exp_adr_q.pop_front()));
                    check("strobe_dat", upg_dat_o, exp_dat_q.pop_front());
                end
            end
            if (upg_done_o && !done_prev) done_cycle = cyc;
            done_prev = upg_done_o;
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        exp_adr_q.delete();
        exp_dat_q.delete();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Reference model: N words from words_q become writes at addresses 0..N-1
    task automatic run_frame(input int n);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
        for (int i = 0; i < n; i++) begin
            exp_adr_q.push_back(ADR_W'(i));
            exp_dat_q.push_back(words_q[i]);
            for (int k = 0; k < 4; k++) begin
                b  = 8'(words_q[i] >> (8 * k));
                cs = cs ^ b;
                send_byte(b, 1'b1);
            end
        end
`ifdef UPG_LOADER_CHECKSUM_EN
        send_byte(cs, 1'b1);
`endif
    endtask

    task automatic check_done(input string tag);
        for (int k = 0; k < 20 * BIT_CYC && upg_done_o !== 1'b1; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check({tag, "_done"}, 32'(upg_done_o), 32'd1);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_pending"}, 32'(exp_adr_q.size()), 32'd0);
    endtask

    initial begin
        int s0;
        int n;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wen", 32'(upg_wen_o), 32'd0);
        check("rst_adr", 32'(upg_adr_o), 32'd0);
        check("rst_dat", upg_dat_o, 32'd0);
        check("rst_done", 32'(upg_done_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);

        do_reset();
        s0 = strobes;
        words_q = '{32'h12345678};
        run_frame(1);
        check_done("single");
        check("single_strobes", 32'(strobes - s0), 32'd1);
`ifndef UPG_LOADER_CHECKSUM_EN
        check("single_done_lat", 32'(done_cycle - strobe_cycle), 32'd1);
`endif

        do_reset();
        s0 = strobes;
        words_q = '{32'h00000001, 32'hDEADBEEF, 32'hFFFFFFFF};
        run_frame(3);
        check_done("three");
        check("three_strobes", 32'(strobes - s0), 32'd3);
        check("three_last_adr", 32'(upg_adr_o), 32'd2);

        do_reset();
        s0 = strobes;
        words_q.delete();
        run_frame(0);
        check_done("zero");
        send_byte(8'hAA, 1'b1);
        repeat (10) @(negedge clk);
        check("zero_strobes", 32'(strobes - s0), 32'd0);
        check("zero_done_kept", 32'(upg_done_o), 32'd1);
        check("zero_err", 32'(err_o), 32'd0);

        do_reset();
        rx = 1'b0;
        repeat (BIT_CYC * 3 / 10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        check("glitch_err", 32'(err_o), 32'd0);
        check("glitch_done", 32'(upg_done_o), 32'd0);
        words_q = '{$urandom};
        run_frame(1);
        check_done("glitch_frame");

        do_reset();
        s0 = strobes;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        check("frame_err", 32'(err_o), 32'd1);
        check("frame_done", 32'(upg_done_o), 32'd0);
        check("frame_busy", 32'(busy_o), 32'd0);
        check("frame_strobes", 32'(strobes - s0), 32'd0);

        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h40, 1'b1);
        repeat (10) @(negedge clk);
        check("oversize_err", 32'(err_o), 32'd1);
        check("oversize_done", 32'(upg_done_o), 32'd0);

        do_reset();
        s0 = strobes;
        exp_adr_q.push_back(ADR_W'(0));
        exp_dat_q.push_back(32'hCAFEF00D);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h0D, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'hCA, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h66, 1'b1);
        check("mid_busy_before", 32'(busy_o), 32'd1);
        #10;
        rstn = 1'b0;
        #1;
        check("mid_rst_wen", 32'(upg_wen_o), 32'd0);
        check("mid_rst_adr", 32'(upg_adr_o), 32'd0);
        check("mid_rst_dat", upg_dat_o, 32'd0);
        check("mid_rst_done", 32'(upg_done_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_err", 32'(err_o), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        words_q = '{$urandom, $urandom};
        run_frame(2);
        check_done("after_reset");
        check("after_reset_strobes", 32'(strobes - s0), 32'd3);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            s0 = strobes;
            n = $urandom_range(1, 4);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            run_frame(n);
            check_done("random");
            check("random_strobes", 32'(strobes - s0), 32'(n));
        end

`ifdef UPG_LOADER_CHECKSUM_EN
        do_reset();
        exp_adr_q.push_back(ADR_W'(0));
        exp_dat_q.push_back(32'h44332211);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h44, 1'b1);
        check_done("chk_ok");

        do_reset();
        exp_adr_q.push_back(ADR_W'(0));
        exp_dat_q.push_back(32'h44332211);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h45, 1'b1);
        repeat (10) @(negedge clk);
        check("chk_bad_err", 32'(err_o), 32'd1);
        check("chk_bad_done", 32'(upg_done_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/upg_uart_loader.md
Name: upg_uart_loader

Overview:
- UART-side initiator for the data-memory programming port.
- Receives a program image over a serial line (8N1, LSB first) and assembles little-endian 32-bit words.
- Drives the upg_wen/upg_adr/upg_dat/upg_done signals consumed by the memory's programming interface.
- Sits between the board RX pin and the data memory; runs on the 10 MHz programming clock.

Parameters:
- CLK_FREQ, 10000000, upg_clk_i frequency in Hz.
- BAUD, 128000, serial bit rate. BIT_CYC = CLK_FREQ/BAUD (integer division), HALF_CYC = BIT_CYC/2.
- ADR_W, 14, word address width.

Ports:
- upg_clk_i  input  1  programming clock.
- upg_rstn_i  input  1  asynchronous active-low reset.
- rx_i  input  1  serial data in, asynchronous to upg_clk_i, idles high.
- upg_wen_o  output  1  one-cycle write strobe to memory.
- upg_adr_o  output  ADR_W  word address of current write.
- upg_dat_o  output  32  write data.
- upg_done_o  output  1  1 = load complete (sticky), 0 = busy/idle.
- busy_o  output  1  transfer in progress.
- err_o  output  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release) sets: upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, busy_o=0, err_o=0. Loader state = S_LEN0, RX state = IDLE.
- rx_i passes through a 2-FF synchronizer; all logic uses the synchronized value.
- RX byte engine:
  - IDLE: a falling edge (sync value 1→0) starts a byte.
  - START: wait HALF_CYC cycles, then sample. If high, it is a false start: return to IDLE, nothing reported.
  - DATA: 8 samples spaced BIT_CYC apart, LSB first.
  - STOP: one sample BIT_CYC after the last data bit. A 1 produces a one-cycle byte_valid. A 0 is a framing error.
  - Returns to IDLE the cycle after STOP.
- Loader FSM, advanced on byte_valid:
  - S_LEN0: N[7:0] → S_LEN1. busy_o goes 1 on the first start-bit detection.
  - S_LEN1: N[15:8]. If N=0 → S_DONE. If N > 2^ADR_W → S_ERR. Otherwise byte counter=0, address=0 → S_DATA.
  - S_DATA: bytes fill the word little-endian (byte0 → [7:0] … byte3 → [31:24]).
    - On the 4th byte's byte_valid, the next cycle has upg_wen_o=1 for exactly one cycle, with upg_adr_o and upg_dat_o valid in that cycle and held afterwards until the next write.
    - Address increments the cycle after the strobe.
    - After write N → S_DONE (or S_CHK when the checksum feature is enabled).
  - S_DONE: upg_done_o=1 and busy_o=0 from the cycle after the last write strobe. Further RX bytes are ignored. Leaves only via reset.
  - S_ERR: err_o=1, busy_o=0, upg_done_o=0, no further strobes. Leaves only via reset.
- A framing error in any loader state other than S_DONE → S_ERR. A partially assembled word is discarded, never written.
- Address wrap is impossible: N is bounded to 2^ADR_W, and the last address is N-1.
- Reset mid-transfer: outputs return to reset values immediately. Already-written words are not rolled back. The host must resend the full frame including the length.
- Throughput: at most one strobe per 40·BIT_CYC cycles; no back-pressure from memory (single-cycle write).

Optional Feature:
- Macro UPG_LOADER_CHECKSUM_EN.
- Defined: after the N data words, one extra byte is expected, equal to the XOR of all 4N data bytes (N=0 → expected 0x00, read in S_CHK before S_DONE).
  - Match: upg_done_o=1 the cycle after the checksum byte_valid.
  - Mismatch: S_ERR, err_o=1, upg_done_o stays 0.
- Undefined: no S_CHK state and no XOR accumulator; done follows the last write as above.

Test Plan:
- Single word: send 01 00 78 56 34 12 → exactly one upg_wen_o pulse with upg_adr_o=0, upg_dat_o=0x12345678; upg_done_o=1 next cycle; busy_o=0.
- Three words: N=3, data 0x00000001, 0xDEADBEEF, 0xFFFFFFFF → strobes at adr 0, 1, 2 with those values, each one cycle wide; done after the third.
- N=0: send 00 00 → no strobe; upg_done_o=1 after the second byte; a third byte 0xAA is ignored.
- Glitch/framing: a 0.3·BIT_CYC low pulse on rx_i → no byte, no error. A byte with stop bit=0 during S_DATA → err_o=1, no strobe for the partial word, done stays 0.
- Reset mid-frame: deassert upg_rstn_i after 2 of 4 data bytes → all outputs return to 0 asynchronously. A subsequent full frame loads correctly from adr 0.
- Checksum (macro defined): N=1, data 11 22 33 44, checksum 0x44 → done=1. Checksum 0x45 → err_o=1, done=0.
